data_mem_param: RTL

DATA_MEM_PARAM -- requirements
Module: data_mem_param

---
 rtl/data_mem_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_param.sv
// Single-port word memory with byte enables and a valid/ready request/response pair.
// After reset an INIT sweep fills every word with INIT_VAL before requests are accepted.
module data_mem_param #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done,
    output logic                  wr_err
);

    localparam int                BE_W      = DATA_W / 8;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                wr_err_q, wr_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                req_ready_s;
    logic                accept_s;
    logic                rd_accept_s;
    logic                wr_accept_s;
    logic                in_range_s;
    logic [IDX_W-1:0]    req_idx_s;
    logic [IDX_W-1:0]    sweep_idx_s;
    logic [DATA_W-1:0]   rd_word_s;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // The response slot may be refilled in the same cycle it is drained.
    assign req_ready_s = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    assign accept_s    = req_valid && req_ready_s;
    assign rd_accept_s = accept_s && !req_write;
    assign wr_accept_s = accept_s && req_write;
    assign in_range_s  = ({1'b0, req_addr} < DEPTH_EXT);
    assign req_idx_s   = req_addr[IDX_W-1:0];
    assign sweep_idx_s = idx_q[IDX_W-1:0];
    assign rd_word_s   = mem_q[req_idx_s];

    // Init sweep sequencing and the INIT -> RUN transition.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    idx_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = ST_INIT;
                idx_d       = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // Response slot and write-error pulse next-state.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_err_d    = wr_accept_s && !in_range_s;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
        if (rd_accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !in_range_s;
            rsp_rdata_d = in_range_s ? rd_word_s : '0;
        end else begin
            rsp_err_d   = rsp_err_q;
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Storage array: sweep writes in INIT, byte-masked writes in RUN; left unreset.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[sweep_idx_s] <= INIT_VAL;
        end else if (wr_accept_s && in_range_s) begin
            mem_q[req_idx_s] <= merge_bytes(rd_word_s, req_wdata, req_be);
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
    assign wr_err    = wr_err_q;

endmodule
